// File: rtl/mul_seq.sv
// Shift-and-add 4x4 unsigned multiply sequencer. It drives the control and data
// inputs of the AH/AL accumulator pair and owns the adder, the carry flop and the step counter.
module mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] ah_out,
  input  logic [WIDTH-1:0] al_out,
  output logic [WIDTH-1:0] ah_in,
  output logic             ah_inen,
  output logic             ah_reset,
  output logic [WIDTH-1:0] aludata,
  output logic             carry_out,
  output logic [1:0]       hs,
  output logic [1:0]       ls,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADH, S_LOADL, S_ADD, S_SHIFT, S_DONE
  } state_t;

  localparam logic [1:0] SH_LOAD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b10;
  localparam logic [1:0] SH_HOLD  = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ah_inen_q, ah_inen_d;
  logic             ah_reset_q, ah_reset_d;
  logic [WIDTH:0]   sum;

  assign sum     = {1'b0, ah_out} + {1'b0, mcand_q};
  assign aludata = sum[WIDTH-1:0];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = mcand;
          mplier_d = mplier;
          state_d  = S_LOADH;
        end
      end
      S_LOADH: state_d = S_LOADL;
      S_LOADL: begin
        cnt_d   = '0;
        carry_d = 1'b0;
        state_d = S_ADD;
      end
      S_ADD: begin
        carry_d = al_out[0] ? sum[WIDTH] : 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? S_DONE : S_ADD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flag outputs are precomputed from the next state so they leave straight from flops.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    ah_inen_d  = (state_d == S_LOADH);
    ah_reset_d = (state_d == S_LOADL);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (clr) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ah_inen_q  <= 1'b0;
      ah_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ah_inen_q  <= ah_inen_d;
      ah_reset_q <= ah_reset_d;
    end
  end

  // Shift codes decode from the state; ADD loads AH only when the current multiplier bit (AL[0]) is set.
  always_comb begin
    hs    = SH_HOLD;
    ls    = SH_HOLD;
    ah_in = '0;
    case (state_q)
      S_LOADH: begin
        hs    = SH_LOAD;
        ah_in = mplier_q;
      end
      S_LOADL: ls = SH_LOAD;
      S_ADD:   if (al_out[0]) hs = SH_LOAD;
      S_SHIFT: begin
        hs = SH_RIGHT;
        ls = SH_RIGHT;
      end
      default: ;
    endcase
  end

  assign carry_out = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ah_inen   = ah_inen_q;
  assign ah_reset  = ah_reset_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: a behavioural AH/AL accumulator closes the loop
// and every product and control output is compared against hand-computed values.
module tb_mul_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] mplier, mcand;
  logic [3:0] ah_out, al_out;
  logic [3:0] ah_in, aludata;
  logic       ah_inen, ah_reset, carry_out, busy, done;
  logic [1:0] hs, ls;

  logic       acc_clr, pre_en;
  logic [3:0] pre_ah, pre_al;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .start(start), .mplier(mplier), .mcand(mcand),
    .ah_out(ah_out), .al_out(al_out), .ah_in(ah_in), .ah_inen(ah_inen),
    .ah_reset(ah_reset), .aludata(aludata), .carry_out(carry_out),
    .hs(hs), .ls(ls), .busy(busy), .done(done)
  );

  // Accumulator model: AH clear has priority; AL loads/shifts from the pre-edge AH.
  always @(posedge clk) begin
    if (acc_clr) begin
      ah_out <= 4'h0;
      al_out <= 4'h0;
    end else if (pre_en) begin
      ah_out <= pre_ah;
      al_out <= pre_al;
    end else begin
      if (ah_reset) ah_out <= 4'h0;
      else case (hs)
        2'b00: ah_out <= ah_inen ? ah_in : aludata;
        2'b01: ah_out <= {ah_out[2:0], 1'b0};
        2'b10: ah_out <= {carry_out, ah_out[3:1]};
        default: ;
      endcase
      case (ls)
        2'b00: al_out <= ah_out;
        2'b01: al_out <= {al_out[2:0], 1'b0};
        2'b10: al_out <= {ah_out[0], al_out[3:1]};
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiply from the accept edge through one idle cycle after DONE.
  // Optionally pulses start in cycles 4 and 11 with other operands, which must be ignored.
  task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                         input bit inject, input logic [3:0] ia, input logic [3:0] ib,
                         output bit carry_seen);
    logic [7:0] exp;
    int step;
    carry_seen = 1'b0;
    mplier = a;
    mcand  = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mplier = ~a;
    mcand  = ~b;
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("busy_c%0d", c), {7'b0, busy}, 8'd1);
      check($sformatf("done_c%0d", c), {7'b0, done}, (c == 11) ? 8'd1 : 8'd0);
      if (c >= 3 && c <= 9 && (c % 2) == 1) begin
        step = (c - 3) / 2;
        check($sformatf("hs_add%0d", step), {6'b0, hs}, a[step] ? 8'd0 : 8'd3);
      end
      if (c >= 4 && c <= 10 && (c % 2) == 0 && carry_out) carry_seen = 1'b1;
      if (inject && (c == 4 || c == 11)) begin
        start  = 1'b1;
        mplier = ia;
        mcand  = ib;
      end else begin
        start = 1'b0;
      end
      if (c < 11) tick();
    end
    exp = {4'b0, a} * {4'b0, b};
    check("product", {ah_out, al_out}, exp);
    tick();
    start = 1'b0;
    check("busy_after", {7'b0, busy}, 8'd0);
    check("done_after", {7'b0, done}, 8'd0);
    check("product_hold", {ah_out, al_out}, exp);
  endtask

  bit seen;

  initial begin
    clr = 1'b1; start = 1'b0; mplier = 4'h0; mcand = 4'h0;
    acc_clr = 1'b0; pre_en = 1'b1; pre_ah = 4'hA; pre_al = 4'h5;
    tick();
    pre_en = 1'b0;
    tick();
    clr = 1'b0;
    tick();
    tick();
    check("rst_hs", {6'b0, hs}, 8'd3);
    check("rst_ls", {6'b0, ls}, 8'd3);
    check("rst_ah_inen", {7'b0, ah_inen}, 8'd0);
    check("rst_ah_reset", {7'b0, ah_reset}, 8'd0);
    check("rst_ah_in", {4'b0, ah_in}, 8'd0);
    check("rst_carry", {7'b0, carry_out}, 8'd0);
    check("rst_busy", {7'b0, busy}, 8'd0);
    check("rst_done", {7'b0, done}, 8'd0);
    check("rst_acc", {ah_out, al_out}, 8'hA5);

    run_mul(4'hF, 4'hF, 1'b0, 4'h0, 4'h0, seen);
    check("carry_seen_15x15", {7'b0, seen}, 8'd1);
    check("prod_225", {ah_out, al_out}, 8'hE1);
    run_mul(4'hB, 4'hD, 1'b0, 4'h0, 4'h0, seen);
    check("prod_143", {ah_out, al_out}, 8'h8F);
    run_mul(4'h0, 4'h9, 1'b0, 4'h0, 4'h0, seen);
    check("carry_mplier0", {7'b0, seen}, 8'd0);
    run_mul(4'h9, 4'h0, 1'b0, 4'h0, 4'h0, seen);
    check("carry_mcand0", {7'b0, seen}, 8'd0);

    // Start pulses while busy are ignored; nothing starts until start returns in IDLE.
    run_mul(4'h7, 4'h6, 1'b1, 4'h2, 4'h2, seen);
    check("prod_42", {ah_out, al_out}, 8'h2A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_busy%0d", i), {7'b0, busy}, 8'd0);
    end
    run_mul(4'hC, 4'hA, 1'b0, 4'h0, 4'h0, seen);
    check("prod_120", {ah_out, al_out}, 8'h78);

    // Abort with clr in cycle 6.
    mplier = 4'h7; mcand = 4'h7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_busy", {7'b0, busy}, 8'd0);
    check("abort_done", {7'b0, done}, 8'd0);
    check("abort_hs", {6'b0, hs}, 8'd3);
    check("abort_ls", {6'b0, ls}, 8'd3);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("abort_nodone%0d", i), {7'b0, done}, 8'd0);
    end
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("acc_cleared", {ah_out, al_out}, 8'h00);
    run_mul(4'h3, 4'h5, 1'b0, 4'h0, 4'h0, seen);
    check("prod_15", {ah_out, al_out}, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
